trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_capture_pkg.sv | 29 ++
 rtl/trace_capture_if.sv | 22 ++
 rtl/trace_fifo.sv | 60 ++++++
 rtl/trace_capture.sv | 119 +++++++++++
 tb/tb_trace_capture.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/trace_capture_pkg.sv
// Shared definitions for the trace capture block: FSM encoding, record layout
// and drop-counter width.
package trace_capture_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int ALU_W   = 32;
    localparam int DROP_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [ALU_W-1:0]   alu;
        logic               reg_write;
    } trace_rec_t;

    // Saturating increment so the drop counter sticks at all-ones.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Read-side handshake of the trace buffer: head entry plus valid/ready.
interface trace_capture_if;
    import trace_capture_pkg::*;

    logic               rd_valid;
    logic               rd_ready;
    logic [PC_W-1:0]    rd_pc;
    logic [INSTR_W-1:0] rd_instr;
    logic [ALU_W-1:0]   rd_alu;
    logic               rd_reg_write;

    modport master (
        output rd_valid, rd_pc, rd_instr, rd_alu, rd_reg_write,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_pc, rd_instr, rd_alu, rd_reg_write,
        output rd_ready
    );

endinterface

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace records with synchronous flush.
// Storage is never reset; only pointers and count are.
module trace_fifo
    import trace_capture_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  trace_rec_t i_wr_data,
    output trace_rec_t o_rd_data,
    output logic [AW:0] o_count,
    output logic       o_push_ok
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    trace_rec_t        r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_pop;
    logic              w_push;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign w_pop     = i_pop && (r_count != '0);
    assign w_push    = i_push && ((r_count != FULL_CNT) || w_pop);
    assign o_push_ok = w_push;
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/trace_capture.sv
// Instruction trace capture: waits for a trigger PC, then records one retired
// instruction per cycle into a FIFO drained by the host.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ALU_W-1:0]   alu_in,
    input  logic               reg_write_in,
    input  logic               arm,
    input  logic               stop,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic               stop_on_full,
    trace_capture_if.master    rd_if,
    output logic [AW:0]        count,
    output logic [DROP_W-1:0]  drop_cnt,
    output logic [1:0]         state
);

    localparam logic [AW:0] LAST_FREE = (AW+1)'(DEPTH-1);

    state_t            r_state;
    state_t            w_state_next;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              w_trig;
    logic              w_push_attempt;
    logic              w_flush;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_end_full;
    logic [AW:0]       w_count;
    trace_rec_t        w_wr_rec;
    trace_rec_t        w_rd_rec;

    assign w_trig = (pc_in == trig_pc);
    assign w_pop  = rd_if.rd_valid && rd_if.rd_ready;

    always_comb begin
        w_wr_rec           = '0;
        w_wr_rec.pc        = pc_in;
        w_wr_rec.instr     = instr_in;
        w_wr_rec.alu       = alu_in;
        w_wr_rec.reg_write = reg_write_in;
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push_attempt),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .i_wr_data (w_wr_rec),
        .o_rd_data (w_rd_rec),
        .o_count   (w_count),
        .o_push_ok (w_push_ok)
    );

    // End-on-full: either this push fills the last slot, or the attempt bounced.
    assign w_end_full = stop_on_full && w_push_attempt &&
                        ((w_push_ok && !w_pop && (w_count == LAST_FREE)) || !w_push_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (arm) w_state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (stop)            w_state_next = ST_DONE;
                else if (w_trig)     w_state_next = w_end_full ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (stop || w_end_full) w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_push_attempt = 1'b0;
        w_flush        = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: w_flush        = arm;
            ST_ARMED:         w_push_attempt = w_trig;
            ST_CAPTURE:       w_push_attempt = 1'b1;
            default:          w_push_attempt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                r_drop_cnt <= '0;
        else if (w_flush)                         r_drop_cnt <= '0;
        else if (w_push_attempt && !w_push_ok)    r_drop_cnt <= sat_inc(r_drop_cnt);
    end

    assign rd_if.rd_valid     = (w_count != '0);
    assign rd_if.rd_pc        = w_rd_rec.pc;
    assign rd_if.rd_instr     = w_rd_rec.instr;
    assign rd_if.rd_alu       = w_rd_rec.alu;
    assign rd_if.rd_reg_write = w_rd_rec.reg_write;

    assign count    = w_count;
    assign drop_cnt = r_drop_cnt;
    assign state    = r_state;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: trigger, stop-on-full, drop counting,
// full-FIFO streaming with wrap, stop on trigger, async reset.
module tb_trace_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic [31:0] alu_in = '0;
    logic        reg_write_in = 1'b0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        stop_on_full = 1'b0;
    logic [4:0]  count;
    logic [15:0] drop_cnt;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    trace_capture_if u_if();

    trace_capture #(.DEPTH(16), .AW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .instr_in     (instr_in),
        .alu_in       (alu_in),
        .reg_write_in (reg_write_in),
        .arm          (arm),
        .stop         (stop),
        .trig_pc      (trig_pc),
        .stop_on_full (stop_on_full),
        .rd_if        (u_if),
        .count        (count),
        .drop_cnt     (drop_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] exp_alu(input logic [31:0] pc);
        return pc + 32'h100;
    endfunction

    function automatic logic exp_rw(input logic [31:0] pc);
        return pc[2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pc(input logic [31:0] pc);
        pc_in        = pc;
        instr_in     = exp_instr(pc);
        alu_in       = exp_alu(pc);
        reg_write_in = exp_rw(pc);
    endtask

    task automatic do_arm(input logic [31:0] tp, input logic sof);
        trig_pc      = tp;
        stop_on_full = sof;
        drive_pc(32'hFFFF_0000);
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        u_if.rd_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (u_if.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", u_if.rd_valid); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        reset = 1'b0;
        tick();
        $display("txn reset: state=%0d count=%0d", state, count);
    endtask

    task automatic test_trigger();
        do_arm(32'h8, 1'b0);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL trig_arm_state: got %0d want 1", state); end
        drive_pc(32'h0); tick();
        drive_pc(32'h4); tick();
        n_cmp++; if (state !== 2'd1 || count !== 5'd0) begin n_err++; $display("FAIL trig_wait: state=%0d count=%0d want 1/0", state, count); end
        drive_pc(32'h8); tick();
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL trig_capture_state: got %0d want 2", state); end
        n_cmp++; if (count !== 5'd1 || u_if.rd_valid !== 1'b1) begin n_err++; $display("FAIL trig_first_count: count=%0d valid=%b want 1/1", count, u_if.rd_valid); end
        n_cmp++; if (u_if.rd_pc !== 32'h8 || u_if.rd_instr !== exp_instr(32'h8) || u_if.rd_alu !== exp_alu(32'h8))
            begin n_err++; $display("FAIL trig_first_entry: pc=%h instr=%h alu=%h want pc=8", u_if.rd_pc, u_if.rd_instr, u_if.rd_alu); end
        drive_pc(32'hC); tick();
        n_cmp++; if (count !== 5'd2 || u_if.rd_pc !== 32'h8) begin n_err++; $display("FAIL trig_second: count=%0d pc=%h want 2/8", count, u_if.rd_pc); end
        stop = 1'b1; drive_pc(32'h10); tick(); stop = 1'b0;
        n_cmp++; if (state !== 2'd3 || count !== 5'd3) begin n_err++; $display("FAIL trig_stop: state=%0d count=%0d want 3/3", state, count); end
        $display("txn trigger: state=%0d count=%0d head_pc=%h", state, count, u_if.rd_pc);
    endtask

    task automatic test_stop_on_full();
        do_arm(32'h100, 1'b1);
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL sof_flush: count=%0d want 0", count); end
        for (int k = 0; k < 20; k++) begin
            drive_pc(32'h100 + 32'(4 * k));
            tick();
        end
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL sof_state: got %0d want 3", state); end
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL sof_count: got %0d want 16", count); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL sof_drop: got %0d want 0", drop_cnt); end
        u_if.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (u_if.rd_valid !== 1'b1 || u_if.rd_pc !== 32'h100 + 32'(4 * i))
                begin n_err++; $display("FAIL sof_drain[%0d]: valid=%b pc=%h want pc=%h", i, u_if.rd_valid, u_if.rd_pc, 32'h100 + 32'(4 * i)); end
            tick();
        end
        u_if.rd_ready = 1'b0;
        n_cmp++; if (count !== 5'd0 || u_if.rd_valid !== 1'b0) begin n_err++; $display("FAIL sof_empty: count=%0d valid=%b want 0/0", count, u_if.rd_valid); end
        $display("txn stop_on_full: state=%0d count=%0d drop=%0d", state, count, drop_cnt);
    endtask

    task automatic test_drop();
        logic [31:0] p;
        do_arm(32'h200, 1'b0);
        for (int k = 0; k < 20; k++) begin
            drive_pc(32'h200 + 32'(4 * k));
            stop = (k == 19);
            tick();
        end
        stop = 1'b0;
        n_cmp++; if (state !== 2'd3 || count !== 5'd16) begin n_err++; $display("FAIL drop_state_count: state=%0d count=%0d want 3/16", state, count); end
        n_cmp++; if (drop_cnt !== 16'd4) begin n_err++; $display("FAIL drop_cnt: got %0d want 4", drop_cnt); end
        u_if.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            p = 32'h200 + 32'(4 * i);
            n_cmp++; if (u_if.rd_pc !== p || u_if.rd_instr !== exp_instr(p) || u_if.rd_alu !== exp_alu(p) || u_if.rd_reg_write !== exp_rw(p))
                begin n_err++; $display("FAIL drop_entry[%0d]: pc=%h instr=%h alu=%h rw=%b want pc=%h", i, u_if.rd_pc, u_if.rd_instr, u_if.rd_alu, u_if.rd_reg_write, p); end
            tick();
        end
        u_if.rd_ready = 1'b0;
        $display("txn drop: drop=%0d count=%0d", drop_cnt, count);
    endtask

    task automatic test_stop_trigger();
        do_arm(32'h500, 1'b0);
        n_cmp++; if (drop_cnt !== 16'd0 || count !== 5'd0) begin n_err++; $display("FAIL st_arm_clear: drop=%0d count=%0d want 0/0", drop_cnt, count); end
        drive_pc(32'h500); stop = 1'b1; tick(); stop = 1'b0;
        n_cmp++; if (state !== 2'd3 || count !== 5'd1) begin n_err++; $display("FAIL st_done: state=%0d count=%0d want 3/1", state, count); end
        n_cmp++; if (u_if.rd_pc !== 32'h500) begin n_err++; $display("FAIL st_entry: pc=%h want 500", u_if.rd_pc); end
        u_if.rd_ready = 1'b1;
        do_arm(32'h600, 1'b0);
        u_if.rd_ready = 1'b0;
        n_cmp++; if (count !== 5'd0 || drop_cnt !== 16'd0 || state !== 2'd1)
            begin n_err++; $display("FAIL st_rearm: count=%0d drop=%0d state=%0d want 0/0/1", count, drop_cnt, state); end
        stop = 1'b1; tick(); stop = 1'b0;
        n_cmp++; if (state !== 2'd3 || count !== 5'd0) begin n_err++; $display("FAIL st_armed_stop: state=%0d count=%0d want 3/0", state, count); end
        $display("txn stop_trigger: state=%0d count=%0d", state, count);
    endtask

    task automatic test_back_to_back();
        do_arm(32'h300, 1'b0);
        for (int k = 0; k < 16; k++) begin
            drive_pc(32'h300 + 32'(4 * k));
            tick();
        end
        n_cmp++; if (count !== 5'd16 || drop_cnt !== 16'd0) begin n_err++; $display("FAIL b2b_fill: count=%0d drop=%0d want 16/0", count, drop_cnt); end
        u_if.rd_ready = 1'b1;
        for (int k = 16; k < 36; k++) begin
            n_cmp++; if (u_if.rd_pc !== 32'h300 + 32'(4 * (k - 16)))
                begin n_err++; $display("FAIL b2b_head[%0d]: pc=%h want %h", k - 16, u_if.rd_pc, 32'h300 + 32'(4 * (k - 16))); end
            drive_pc(32'h300 + 32'(4 * k));
            tick();
            n_cmp++; if (count !== 5'd16 || drop_cnt !== 16'd0)
                begin n_err++; $display("FAIL b2b_steady[%0d]: count=%0d drop=%0d want 16/0", k, count, drop_cnt); end
        end
        stop = 1'b1; drive_pc(32'h300 + 32'(4 * 36)); tick(); stop = 1'b0;
        u_if.rd_ready = 1'b0;
        n_cmp++; if (state !== 2'd3 || count !== 5'd16) begin n_err++; $display("FAIL b2b_stop: state=%0d count=%0d want 3/16", state, count); end
        u_if.rd_ready = 1'b1;
        for (int i = 21; i < 37; i++) begin
            n_cmp++; if (u_if.rd_pc !== 32'h300 + 32'(4 * i))
                begin n_err++; $display("FAIL b2b_drain[%0d]: pc=%h want %h", i, u_if.rd_pc, 32'h300 + 32'(4 * i)); end
            tick();
        end
        u_if.rd_ready = 1'b0;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL b2b_empty: count=%0d want 0", count); end
        $display("txn back_to_back: state=%0d count=%0d drop=%0d", state, count, drop_cnt);
    endtask

    task automatic test_async_reset();
        do_arm(32'h400, 1'b0);
        for (int k = 0; k < 7; k++) begin
            drive_pc(32'h400 + 32'(4 * k));
            tick();
        end
        n_cmp++; if (count !== 5'd7 || state !== 2'd2) begin n_err++; $display("FAIL ar_pre: count=%0d state=%0d want 7/2", count, state); end
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (u_if.rd_valid !== 1'b0 || count !== 5'd0 || state !== 2'd0)
            begin n_err++; $display("FAIL ar_async: valid=%b count=%0d state=%0d want 0/0/0", u_if.rd_valid, count, state); end
        #1 reset = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd0 || count !== 5'd0) begin n_err++; $display("FAIL ar_after: state=%0d count=%0d want 0/0", state, count); end
        $display("txn async_reset: state=%0d count=%0d", state, count);
    endtask

    initial begin
        u_if.rd_ready = 1'b0;
        test_reset();
        test_trigger();
        test_stop_on_full();
        test_drop();
        test_stop_trigger();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
